csr_resp_unit: RTL and testbench

//   Machine-mode CSR responder: serves same-cycle CSR reads from the EX-stage CSR requester, commits
//   WB-stage CSR writes, runs mcycle/minstret, and sequences trap entry (ecall/exception/interrupt)
//   and mret, issuing a one-cycle PC redirect to fetch. Single hart, RV32 Zicsr M-mode subset.

---
 rtl/csr_resp_unit_if.sv | 38 +++
 rtl/csr_resp_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_csr_resp_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/csr_resp_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_resp_unit_if
// Brief    : CSR read/write, trap/mret and redirect bundle of csr_resp_unit.
// Revision : 1.0
// ============================================================================
interface csr_resp_unit_if;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_illegal;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [5:0]  trap_cause;
    logic [31:0] trap_val;
    logic        ecall;
    logic        mret;
    logic        instret;
    logic        branch_valid;
    logic [31:0] branch_addr;
    logic        busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
               trap_req, trap_pc, trap_cause, trap_val, ecall, mret, instret,
        input  rd_data, rd_illegal, branch_valid, branch_addr, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
               trap_req, trap_pc, trap_cause, trap_val, ecall, mret, instret,
        output rd_data, rd_illegal, branch_valid, branch_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/csr_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_resp_unit
// Brief    : RV32 M-mode CSR responder with counters, trap entry and mret.
//            Define CSR_VECTORED_EN to enable vectored mtvec mode.
// Revision : 1.0
// ============================================================================
module csr_resp_unit #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    csr_resp_unit_if.slave    bus
);

    localparam logic [11:0] c_mstatus   = 12'h300;
    localparam logic [11:0] c_misa      = 12'h301;
    localparam logic [11:0] c_mie       = 12'h304;
    localparam logic [11:0] c_mtvec     = 12'h305;
    localparam logic [11:0] c_mscratch  = 12'h340;
    localparam logic [11:0] c_mepc      = 12'h341;
    localparam logic [11:0] c_mcause    = 12'h342;
    localparam logic [11:0] c_mtval     = 12'h343;
    localparam logic [11:0] c_mip       = 12'h344;
    localparam logic [11:0] c_mcycle    = 12'hB00;
    localparam logic [11:0] c_minstret  = 12'hB02;
    localparam logic [11:0] c_mcycleh   = 12'hB80;
    localparam logic [11:0] c_minstreth = 12'hB82;
    localparam logic [11:0] c_mhartid   = 12'hF14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_MRET = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_mie_bit;
    logic        r_mpie_bit;
    logic [31:0] r_mie;
    logic [29:0] r_mtvec_base;
    logic [1:0]  w_mtvec_mode;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic        w_take_trap;
    logic        w_take_mret;
    logic [31:0] w_trap_target;
    logic [31:0] w_mstatus;

    function automatic logic wr_hit(input logic en, input logic [11:0] a, input logic [11:0] c);
        return en && (a == c);
    endfunction

    // Trap sources outrank mret; nothing is accepted outside IDLE.
    assign w_take_trap = (r_state == ST_IDLE) && (bus.trap_req || bus.ecall);
    assign w_take_mret = (r_state == ST_IDLE) && !bus.trap_req && !bus.ecall && bus.mret;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie_bit, 3'd0, r_mie_bit, 3'd0};

    // ------------------------------------------------------------------------
    // mtvec: mode bits only exist in the vectored build
    // ------------------------------------------------------------------------
`ifdef CSR_VECTORED_EN
    logic [1:0] r_mtvec_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec_mode <= MTVEC_RESET[1:0];
        end else if (wr_hit(bus.wr_en, bus.wr_addr, c_mtvec) && !bus.wr_data[1]) begin
            r_mtvec_mode <= bus.wr_data[1:0];
        end
    end

    assign w_mtvec_mode  = r_mtvec_mode;
    assign w_trap_target = (r_mtvec_mode == 2'b01 && r_mcause[31])
                         ? {r_mtvec_base, 2'b00} + {25'd0, r_mcause[4:0], 2'b00}
                         : {r_mtvec_base, 2'b00};
`else
    assign w_mtvec_mode  = 2'b00;
    assign w_trap_target = {r_mtvec_base, 2'b00};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec_base <= MTVEC_RESET[31:2];
            r_mie        <= 32'd0;
            r_mscratch   <= 32'd0;
        end else begin
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mtvec))    r_mtvec_base <= bus.wr_data[31:2];
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mie))      r_mie        <= bus.wr_data;
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mscratch)) r_mscratch   <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Trap-affected CSRs: trap/mret updates beat a same-edge software write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie_bit  <= 1'b0;
            r_mpie_bit <= 1'b0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
        end else if (w_take_trap) begin
            r_mpie_bit <= r_mie_bit;
            r_mie_bit  <= 1'b0;
            r_mepc     <= {bus.trap_pc[31:2], 2'b00};
            if (bus.trap_req) begin
                r_mcause <= {bus.trap_cause[5], 26'd0, bus.trap_cause[4:0]};
                r_mtval  <= bus.trap_val;
            end else begin
                r_mcause <= 32'd11;
                r_mtval  <= 32'd0;
            end
        end else if (w_take_mret) begin
            r_mie_bit  <= r_mpie_bit;
            r_mpie_bit <= 1'b1;
        end else begin
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mstatus)) begin
                r_mie_bit  <= bus.wr_data[3];
                r_mpie_bit <= bus.wr_data[7];
            end
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mepc))   r_mepc   <= {bus.wr_data[31:2], 2'b00};
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mcause)) r_mcause <= bus.wr_data;
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mtval))  r_mtval  <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // 64-bit counters; a software write to either half freezes that edge
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (wr_hit(bus.wr_en, bus.wr_addr, c_mcycle))
                r_mcycle[31:0] <= bus.wr_data;
            else if (wr_hit(bus.wr_en, bus.wr_addr, c_mcycleh))
                r_mcycle[63:32] <= bus.wr_data;
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (wr_hit(bus.wr_en, bus.wr_addr, c_minstret))
                r_minstret[31:0] <= bus.wr_data;
            else if (wr_hit(bus.wr_en, bus.wr_addr, c_minstreth))
                r_minstret[63:32] <= bus.wr_data;
            else if (bus.instret)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Combinational read port
    // ------------------------------------------------------------------------
    always_comb begin
        logic w_hit;
        w_hit       = 1'b1;
        bus.rd_data = 32'd0;
        case (bus.rd_addr)
            c_mstatus:   bus.rd_data = w_mstatus;
            c_misa:      bus.rd_data = MISA_VAL;
            c_mie:       bus.rd_data = r_mie;
            c_mtvec:     bus.rd_data = {r_mtvec_base, w_mtvec_mode};
            c_mscratch:  bus.rd_data = r_mscratch;
            c_mepc:      bus.rd_data = r_mepc;
            c_mcause:    bus.rd_data = r_mcause;
            c_mtval:     bus.rd_data = r_mtval;
            c_mip:       bus.rd_data = 32'd0;
            c_mcycle:    bus.rd_data = r_mcycle[31:0];
            c_mcycleh:   bus.rd_data = r_mcycle[63:32];
            c_minstret:  bus.rd_data = r_minstret[31:0];
            c_minstreth: bus.rd_data = r_minstret[63:32];
            c_mhartid:   bus.rd_data = HART_ID;
            default:     w_hit       = 1'b0;
        endcase
        bus.rd_illegal = bus.rd_en && !w_hit;
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.branch_valid = 1'b0;
        bus.branch_addr  = 32'd0;
        bus.busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take_trap)      w_state_nxt = ST_TRAP;
                else if (w_take_mret) w_state_nxt = ST_MRET;
            end
            ST_TRAP: begin
                bus.branch_valid = 1'b1;
                bus.branch_addr  = w_trap_target;
                bus.busy         = 1'b1;
                w_state_nxt      = ST_IDLE;
            end
            ST_MRET: begin
                bus.branch_valid = 1'b1;
                bus.branch_addr  = r_mepc;
                bus.busy         = 1'b1;
                w_state_nxt      = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_resp_unit
// Brief    : Directed self-checking bench for csr_resp_unit.
// Revision : 1.0
// ============================================================================
module tb_csr_resp_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    csr_resp_unit_if bus();

    csr_resp_unit #(
        .HART_ID     (32'd0),
        .MTVEC_RESET (32'h0000_0000),
        .MISA_VAL    (32'h4000_0100)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        #1;
        d = bus.rd_data;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = 12'h0;
        bus.wr_en = 1'b1; bus.wr_addr = 12'h305; bus.wr_data = 32'h123;
        bus.trap_req = 1'b1; bus.trap_pc = 32'h40; bus.trap_cause = 6'd2; bus.trap_val = 32'h5;
        bus.ecall = 1'b0; bus.mret = 1'b0; bus.instret = 1'b1;

        // Reset held with write/trap activity
        repeat (3) step();
        chk("rst_branch_valid", {31'd0, bus.branch_valid}, 32'd0);
        chk("rst_branch_addr", bus.branch_addr, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rd(12'h305, v); chk("rst_mtvec", v, 32'h0);
        rd(12'hB00, v); chk("rst_mcycle", v, 32'h0);
        bus.rd_en = 1'b1; bus.rd_addr = 12'hFFF; #1;
        chk("rst_rd_illegal", {31'd0, bus.rd_illegal}, 32'd1);
        bus.rd_en = 1'b0;

        bus.wr_en = 1'b0; bus.trap_req = 1'b0; bus.instret = 1'b0;
        rst_n = 1'b1;
        rd(12'hB00, v); chk("mcycle_after_release", v, 32'd0);
        step();
        rd(12'hB00, v); chk("mcycle_one", v, 32'd1);

        // ecall into direct mtvec
        wr(12'h305, 32'h100);
        rd(12'h305, v); chk("mtvec_wr", v, 32'h100);
        wr(12'h300, 32'h8);
        rd(12'h300, v); chk("mstatus_mie", v, 32'h1808);
        bus.ecall = 1'b1; bus.trap_pc = 32'h80;
        step();
        bus.ecall = 1'b0;
        chk("ecall_bv", {31'd0, bus.branch_valid}, 32'd1);
        chk("ecall_addr", bus.branch_addr, 32'h100);
        chk("ecall_busy", {31'd0, bus.busy}, 32'd1);
        rd(12'h341, v); chk("ecall_mepc", v, 32'h80);
        rd(12'h342, v); chk("ecall_mcause", v, 32'd11);
        rd(12'h343, v); chk("ecall_mtval", v, 32'd0);
        rd(12'h300, v); chk("ecall_mstatus", v, 32'h1880);
        step();
        chk("ecall_idle_bv", {31'd0, bus.branch_valid}, 32'd0);
        chk("ecall_idle_busy", {31'd0, bus.busy}, 32'd0);

        // mret back to mepc
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        chk("mret_bv", {31'd0, bus.branch_valid}, 32'd1);
        chk("mret_addr", bus.branch_addr, 32'h80);
        rd(12'h300, v); chk("mret_mstatus", v, 32'h1888);
        step();
        chk("mret_idle_busy", {31'd0, bus.busy}, 32'd0);

        // trap_req + mret + mepc write on the same edge
        bus.trap_req = 1'b1; bus.mret = 1'b1; bus.trap_pc = 32'h200;
        bus.trap_cause = 6'd2; bus.trap_val = 32'hDEAD;
        bus.wr_en = 1'b1; bus.wr_addr = 12'h341; bus.wr_data = 32'h44;
        step();
        bus.trap_req = 1'b0; bus.mret = 1'b0; bus.wr_en = 1'b0;
        chk("coll_addr", bus.branch_addr, 32'h100);
        rd(12'h341, v); chk("coll_mepc", v, 32'h200);
        rd(12'h342, v); chk("coll_mcause", v, 32'd2);
        rd(12'h343, v); chk("coll_mtval", v, 32'hDEAD);
        rd(12'h300, v); chk("coll_mstatus", v, 32'h1880);
        step();
        chk("coll_no_mret", {31'd0, bus.branch_valid}, 32'd0);
        step();
        chk("coll_no_mret2", {31'd0, bus.branch_valid}, 32'd0);

        // Interrupt with mtvec mode bit set
        wr(12'h305, 32'h201);
        bus.trap_req = 1'b1; bus.trap_cause = 6'h27; bus.trap_pc = 32'h300;
        step();
        bus.trap_req = 1'b0;
`ifdef CSR_VECTORED_EN
        chk("irq_addr", bus.branch_addr, 32'h21C);
`else
        chk("irq_addr", bus.branch_addr, 32'h200);
`endif
        rd(12'h342, v); chk("irq_mcause", v, 32'h8000_0007);
        step();

        // Counter wrap
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB00, v); chk("mcycle_lo_max", v, 32'hFFFF_FFFF);
        rd(12'hB80, v); chk("mcycle_hi_max", v, 32'hFFFF_FFFF);
        step();
        rd(12'hB00, v); chk("mcycle_lo_wrap", v, 32'd0);
        rd(12'hB80, v); chk("mcycle_hi_wrap", v, 32'd0);

        // minstret counts only pulses
        bus.instret = 1'b1;
        repeat (3) step();
        bus.instret = 1'b0;
        step();
        rd(12'hB02, v); chk("minstret", v, 32'd3);

        // Read-only and unimplemented addresses
        bus.rd_en = 1'b1; bus.rd_addr = 12'hFFF; #1;
        chk("illegal_flag", {31'd0, bus.rd_illegal}, 32'd1);
        chk("illegal_data", bus.rd_data, 32'd0);
        bus.rd_en = 1'b0; #1;
        chk("illegal_no_en", {31'd0, bus.rd_illegal}, 32'd0);
        wr(12'h301, 32'h0);
        rd(12'h301, v); chk("misa_ro", v, 32'h4000_0100);
        rd(12'hF14, v); chk("mhartid", v, 32'd0);
        bus.rd_en = 1'b1; bus.rd_addr = 12'h340; #1;
        chk("mscratch_legal", {31'd0, bus.rd_illegal}, 32'd0);
        bus.rd_en = 1'b0;

        // Reset while in TRAP aborts the redirect
        bus.trap_req = 1'b1;
        step();
        bus.trap_req = 1'b0;
        chk("pre_abort_bv", {31'd0, bus.branch_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_bv", {31'd0, bus.branch_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("abort_idle_bv", {31'd0, bus.branch_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
